// File: rtl/pll_lock_monitor.sv
// Multi-channel PLL lock supervisor in the clkin1 domain: drives each PLL reset, qualifies the
// synchronised lock, tracks loss/timeout with bounded auto-retry and reports a global chk_ok.
module pll_lock_monitor #(
  parameter int N_CH            = 2,
  parameter int SYNC_STAGES     = 3,
  parameter int RST_CYC         = 8,
  parameter int LOCK_STABLE_CYC = 16,
  parameter int LOCK_TIMEOUT    = 1024,
  parameter int MAX_RETRY       = 3,
  localparam int RW             = $clog2(MAX_RETRY + 1)
) (
  input  logic               clkin1,
  input  logic               rst,
  input  logic [N_CH-1:0]    lock,
  input  logic               clr_sticky,
  output logic [N_CH-1:0]    pll_rst,
  output logic [N_CH-1:0]    lock_ok,
  output logic [N_CH-1:0]    lock_lost,
  output logic [N_CH-1:0]    lock_fail,
  output logic [N_CH*RW-1:0] retry_cnt,
  output logic               chk_ok
);

  localparam int RCW = $clog2(RST_CYC + 1);
  localparam int TW  = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW  = $clog2(LOCK_STABLE_CYC + 1);
  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYC - 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0]  STAB_MAX  = SW'(LOCK_STABLE_CYC);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    QUALIFY   = 3'd2,
    LOCKED    = 3'd3,
    FAIL      = 3'd4
  } state_e;

  logic chk_ok_q, chk_ok_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [RCW-1:0]         rcnt_q, rcnt_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [SW-1:0]          stab_q, stab_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic                   lost_q, lost_d;
    logic                   lock_s, retry_go, loss;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], lock[i]};
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      tmo_d    = tmo_q;
      stab_d   = stab_q;
      retry_d  = retry_q;
      retry_go = 1'b0;
      loss     = 1'b0;
      case (state_q)
        RESET_PLL: begin
          if (rcnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            rcnt_d  = '0;
            tmo_d   = '0;
            stab_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCW'(1);
          end
        end
        WAIT_LOCK: begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_q == TMO_LAST) begin
            retry_go = 1'b1;
          end else if (lock_s) begin
            state_d = QUALIFY;
            stab_d  = SW'(1);
          end
        end
        // A completed qualification wins over a timeout landing on the same cycle.
        QUALIFY: begin
          tmo_d = tmo_q + TW'(1);
          if (lock_s && (stab_q == STAB_MAX)) begin
            state_d = LOCKED;
          end else if (tmo_q == TMO_LAST) begin
            retry_go = 1'b1;
          end else if (lock_s) begin
            stab_d = stab_q + SW'(1);
          end else begin
            state_d = WAIT_LOCK;
            stab_d  = '0;
          end
        end
        LOCKED: begin
          if (!lock_s) begin
            loss     = 1'b1;
            retry_go = 1'b1;
          end
        end
        FAIL: begin
          if (clr_sticky) begin
            state_d = RESET_PLL;
            rcnt_d  = '0;
            retry_d = '0;
          end
        end
        default: state_d = RESET_PLL;
      endcase
      if (retry_go) begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + RW'(1);
          state_d = RESET_PLL;
          rcnt_d  = '0;
        end else begin
          state_d = FAIL;
        end
      end
      // A loss on the clearing cycle must survive the clear.
      lost_d = loss | (lost_q & ~clr_sticky);
    end

    always_ff @(posedge clkin1 or posedge rst) begin
      if (rst) begin
        state_q <= RESET_PLL;
        sync_q  <= '0;
        rcnt_q  <= '0;
        tmo_q   <= '0;
        stab_q  <= '0;
        retry_q <= '0;
        lost_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        sync_q  <= sync_d;
        rcnt_q  <= rcnt_d;
        tmo_q   <= tmo_d;
        stab_q  <= stab_d;
        retry_q <= retry_d;
        lost_q  <= lost_d;
      end
    end

    assign pll_rst[i]             = (state_q == RESET_PLL) || (state_q == FAIL);
    assign lock_ok[i]             = (state_q == LOCKED);
    assign lock_fail[i]           = (state_q == FAIL);
    assign lock_lost[i]           = lost_q;
    assign retry_cnt[i*RW +: RW]  = retry_q;
  end

  always_comb begin
    chk_ok_d = (&lock_ok) & ~(|lock_lost) & ~(|lock_fail);
  end

  always_ff @(posedge clkin1 or posedge rst) begin
    if (rst) begin
      chk_ok_q <= 1'b0;
    end else begin
      chk_ok_q <= chk_ok_d;
    end
  end

  assign chk_ok = chk_ok_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor with default parameters; timings are hand-derived from
// 3 sync stages, 8-cycle PLL reset, 16 stable cycles and a 1024-cycle timeout.
`timescale 1ns/100ps
module tb_pll_lock_monitor;

  logic       clkin1 = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] lock = 2'b00;
  logic       clr_sticky = 1'b0;
  logic [1:0] pll_rst, lock_ok, lock_lost, lock_fail;
  logic [3:0] retry_cnt;
  logic       chk_ok;
  int total = 0;
  int bad = 0;

  pll_lock_monitor dut (
    .clkin1(clkin1), .rst(rst), .lock(lock), .clr_sticky(clr_sticky),
    .pll_rst(pll_rst), .lock_ok(lock_ok), .lock_lost(lock_lost), .lock_fail(lock_fail),
    .retry_cnt(retry_cnt), .chk_ok(chk_ok)
  );

  always #18.5 clkin1 = ~clkin1;

  task automatic tick(input int n);
    repeat (n) @(posedge clkin1);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #50;
    total++; if (pll_rst !== 2'b11) begin bad++; $display("FAIL rst_pll_rst got %b want 11", pll_rst); end
    total++; if ({lock_ok, lock_lost, lock_fail} !== 6'b0) begin bad++; $display("FAIL rst_flags got %b want 0", {lock_ok, lock_lost, lock_fail}); end
    total++; if ({retry_cnt, chk_ok} !== 5'b0) begin bad++; $display("FAIL rst_cnt_chk got %b want 0", {retry_cnt, chk_ok}); end
    #50;
    @(posedge clkin1); #1 rst = 1'b0;
    tick(7);
    total++; if (pll_rst !== 2'b11) begin bad++; $display("FAIL pll_rst_len7 got %b want 11", pll_rst); end
    tick(1);
    total++; if (pll_rst !== 2'b00) begin bad++; $display("FAIL pll_rst_len8 got %b want 00", pll_rst); end
  endtask

  task automatic test_lock_latency();
    tick(20);
    lock[0] = 1'b1;
    tick(19);
    total++; if (lock_ok[0] !== 1'b0) begin bad++; $display("FAIL lat_early got %b want 0", lock_ok[0]); end
    tick(1);
    total++; if (lock_ok[0] !== 1'b1) begin bad++; $display("FAIL lat_exact got %b want 1", lock_ok[0]); end
    tick(1);
    total++; if (chk_ok !== 1'b0) begin bad++; $display("FAIL chk_one_ch got %b want 0", chk_ok); end
  endtask

  task automatic test_requalify();
    lock[1] = 1'b1;
    tick(10);
    lock[1] = 1'b0;
    tick(2);
    lock[1] = 1'b1;
    tick(8);
    total++; if (lock_ok[1] !== 1'b0) begin bad++; $display("FAIL requal_no_old got %b want 0", lock_ok[1]); end
    tick(11);
    total++; if (lock_ok[1] !== 1'b0) begin bad++; $display("FAIL requal_early got %b want 0", lock_ok[1]); end
    tick(1);
    total++; if (lock_ok[1] !== 1'b1) begin bad++; $display("FAIL requal_exact got %b want 1", lock_ok[1]); end
    tick(1);
    total++; if (chk_ok !== 1'b1) begin bad++; $display("FAIL chk_both got %b want 1", chk_ok); end
  endtask

  task automatic test_loss_retry();
    lock[0] = 1'b0;
    tick(3);
    total++; if ({lock_ok[0], lock_lost[0]} !== 2'b10) begin bad++; $display("FAIL loss_pre got %b want 10", {lock_ok[0], lock_lost[0]}); end
    tick(1);
    total++; if ({lock_ok[0], lock_lost[0], pll_rst[0]} !== 3'b011) begin bad++; $display("FAIL loss_flags got %b want 011", {lock_ok[0], lock_lost[0], pll_rst[0]}); end
    total++; if (retry_cnt[1:0] !== 2'd1) begin bad++; $display("FAIL loss_retry got %0d want 1", retry_cnt[1:0]); end
    tick(1);
    total++; if (chk_ok !== 1'b0) begin bad++; $display("FAIL loss_chk got %b want 0", chk_ok); end
    lock[0] = 1'b1;
    tick(6);
    total++; if (pll_rst[0] !== 1'b1) begin bad++; $display("FAIL loss_pulse7 got %b want 1", pll_rst[0]); end
    tick(1);
    total++; if (pll_rst[0] !== 1'b0) begin bad++; $display("FAIL loss_pulse8 got %b want 0", pll_rst[0]); end
    tick(16);
    total++; if (lock_ok[0] !== 1'b0) begin bad++; $display("FAIL relock_early got %b want 0", lock_ok[0]); end
    tick(1);
    total++; if (lock_ok[0] !== 1'b1) begin bad++; $display("FAIL relock got %b want 1", lock_ok[0]); end
    tick(2);
    total++; if (chk_ok !== 1'b0) begin bad++; $display("FAIL chk_sticky got %b want 0", chk_ok); end
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    total++; if (lock_lost !== 2'b00) begin bad++; $display("FAIL clr_lost got %b want 00", lock_lost); end
    total++; if (retry_cnt[1:0] !== 2'd1) begin bad++; $display("FAIL retry_kept got %0d want 1", retry_cnt[1:0]); end
    tick(1);
    total++; if (chk_ok !== 1'b1) begin bad++; $display("FAIL chk_after_clr got %b want 1", chk_ok); end
  endtask

  task automatic test_clr_same_cycle();
    lock[0] = 1'b0;
    tick(3);
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    total++; if (lock_lost[0] !== 1'b1) begin bad++; $display("FAIL clr_vs_loss got %b want 1", lock_lost[0]); end
    total++; if (retry_cnt[1:0] !== 2'd2) begin bad++; $display("FAIL clr_vs_loss_retry got %0d want 2", retry_cnt[1:0]); end
    lock[0] = 1'b1;
  endtask

  task automatic test_rst_mid();
    tick(16);
    total++; if ({lock_ok, pll_rst[0]} !== 3'b100) begin bad++; $display("FAIL mid_state got %b want 100", {lock_ok, pll_rst[0]}); end
    rst = 1'b1;
    #1;
    total++; if (pll_rst !== 2'b11) begin bad++; $display("FAIL mid_pll_rst got %b want 11", pll_rst); end
    total++; if ({lock_ok, lock_lost, lock_fail, retry_cnt, chk_ok} !== 11'b0) begin bad++; $display("FAIL mid_outs got %b want 0", {lock_ok, lock_lost, lock_fail, retry_cnt, chk_ok}); end
    lock = 2'b01;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic test_timeout_fail();
    tick(1031);
    total++; if ({retry_cnt[3:2], pll_rst[1]} !== 3'b000) begin bad++; $display("FAIL tmo_pre got %b want 000", {retry_cnt[3:2], pll_rst[1]}); end
    tick(1);
    total++; if ({retry_cnt[3:2], pll_rst[1]} !== 3'b011) begin bad++; $display("FAIL tmo_first got %b want 011", {retry_cnt[3:2], pll_rst[1]}); end
    tick(3095);
    total++; if ({retry_cnt[3:2], lock_fail[1]} !== 3'b110) begin bad++; $display("FAIL tmo_pre_fail got %b want 110", {retry_cnt[3:2], lock_fail[1]}); end
    tick(1);
    total++; if ({lock_fail[1], pll_rst[1]} !== 2'b11) begin bad++; $display("FAIL tmo_fail got %b want 11", {lock_fail[1], pll_rst[1]}); end
    tick(50);
    total++; if ({lock_fail[1], pll_rst[1], retry_cnt[3:2], chk_ok} !== 5'b11110) begin bad++; $display("FAIL fail_held got %b want 11110", {lock_fail[1], pll_rst[1], retry_cnt[3:2], chk_ok}); end
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    total++; if ({lock_fail[1], pll_rst[1], retry_cnt[3:2]} !== 4'b0100) begin bad++; $display("FAIL fail_clr got %b want 0100", {lock_fail[1], pll_rst[1], retry_cnt[3:2]}); end
    total++; if (lock_ok[0] !== 1'b1) begin bad++; $display("FAIL ch0_indep got %b want 1", lock_ok[0]); end
  endtask

  initial begin
    test_reset();
    test_lock_latency();
    test_requalify();
    test_loss_retry();
    test_clr_same_cycle();
    test_rst_mid();
    test_timeout_fail();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
